jerry_ctl: RTL
==============

Name: jerry_ctl

Overview:
Movement controller for the Jerry sprite. Samples player controls once per frame, applies horizontal stepping with wall clamping and a jump/gravity state machine, and drives the registered Jerry position consumed by draw_jerry. Sits between the keyboard decoder and draw_jerry, in the pixel clock domain.

Parameters:
X_START, 100, x position after reset
X_MIN, 0, leftmost allowed x
X_MAX, 980, rightmost allowed x
GROUND_Y, 500, floor y (Jerry standing)
Y_MIN, 0, ceiling y
STEP_X, 4, horizontal pixels per frame
JUMP_V0, 16, initial upward velocity (px/frame)
GRAVITY, 1, velocity change per frame
V_MAX, 16, maximum falling velocity

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
vblnk  in  1  vertical blank from timing chain; its rising edge is the frame tick
left  in  1  move-left request, level
right  in  1  move-right request, level
jump  in  1  jump request, level
freeze  in  1  hold position and state (game paused/over)
jerry_pos  pos_if.out  11+11  registered Jerry top-left x, y
airborne  out  1  high when state is not STANDING

Behaviour:
- Reset (async, rst=1): x=X_START, y=GROUND_Y, vel=0, state=STANDING, airborne=0, vblnk_q=0.
- Frame tick: tick = vblnk & ~vblnk_q (vblnk_q registered). All updates happen only on the clk edge where tick=1. Outputs change 1 clk after the tick edge and are stable for the rest of the frame.
- freeze=1 on a tick: no change to x, y, vel or state; vblnk_q still tracks.
- Horizontal (every tick, any state): left only -> x-STEP_X; right only -> x+STEP_X; both or neither -> unchanged. Clamp: if x<X_MIN+STEP_X on a left step, x=X_MIN; if x+STEP_X>X_MAX on a right step, x=X_MAX. No wrap-around.
- FSM, 3 states, vel is unsigned 6 bits:
  STANDING: y=GROUND_Y. On tick with jump=1 -> JUMP_UP, vel=JUMP_V0; y unchanged this tick.
  JUMP_UP: y=y-vel, vel=vel-GRAVITY; if new vel==0 -> FALL. Ceiling: if y-vel<Y_MIN then y=Y_MIN, vel=0, -> FALL.
  FALL: vel=min(vel+GRAVITY, V_MAX); y=y+new vel; if that sum>=GROUND_Y then y=GROUND_Y, vel=0, -> STANDING.
- Jump is level-sensitive. Holding jump re-triggers on the first tick after landing, not on the landing tick itself.
- The jump input is ignored in JUMP_UP and FALL.
- With defaults: rise of 136 px over 16 ticks, fall of 136 px over 16 ticks, exact landing.
- Arithmetic: x, y computed in 12 bits before clamping, so no underflow or overflow reaches the output.
- airborne = (state != STANDING), registered together with the position.
- Reset asserted mid-jump: immediate return to reset values, no residual velocity.

Decomposition:
- game_pkg gains JERRY_STEP_X, JERRY_JUMP_V0, JERRY_GRAVITY, JERRY_V_MAX, JERRY_GROUND_Y and the typedef jerry_state_t (STANDING, JUMP_UP, FALL). Module parameters default to these constants.
- One natural sub-module, frame_tick: a rising-edge detector on vblnk that other movers will reuse.

Test Plan:
- Reset release, no inputs, 3 frames -> x=100, y=500, airborne=0 throughout.
- right held 5 frames -> x=120 after the 5th tick, updated 1 clk after each vblnk rise; both left and right held -> x unchanged.
- left held from x=100 for 30 frames -> x goes 96, 92 … 0, then stays 0. Start at x=978 with right held -> x=980 and stays 980.
- jump pulse spanning one tick -> airborne=1; y=364 after 16 more ticks; y=500 and airborne=0 after 32 more ticks. jump held continuously -> a new jump starts on the tick after landing.
- Y_MIN=400 with a jump -> y clamps at 400, FALL begins, y returns to 500.
- freeze=1 mid-jump for 10 frames -> y and vel frozen, then resume the identical trajectory. rst pulse mid-jump -> x=100, y=500, airborne=0 asynchronously.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and types for sprite movers.
// Jerry's position and velocity widths live here.
package game_pkg;

  localparam int POS_W = 11;
  localparam int VEL_W = 6;

  localparam int unsigned JERRY_X_START  = 100;
  localparam int unsigned JERRY_X_MIN    = 0;
  localparam int unsigned JERRY_X_MAX    = 980;
  localparam int unsigned JERRY_GROUND_Y = 500;
  localparam int unsigned JERRY_Y_MIN    = 0;
  localparam int unsigned JERRY_STEP_X   = 4;
  localparam int unsigned JERRY_JUMP_V0  = 16;
  localparam int unsigned JERRY_GRAVITY  = 1;
  localparam int unsigned JERRY_V_MAX    = 16;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [VEL_W-1:0] vel_t;

  typedef enum logic [1:0] {
    STANDING = 2'd0,
    JUMP_UP  = 2'd1,
    FALL     = 2'd2
  } jerry_state_t;

  // One horizontal step with wall clamping; widened to 12 bits so it cannot wrap.
  function automatic pos_t step_x(input pos_t x, input logic left, input logic right,
                                  input int unsigned step, input int unsigned x_min,
                                  input int unsigned x_max);
    logic [POS_W:0] xe;
    xe = {1'b0, x};
    if (left && !right) begin
      return (xe < 12'(x_min + step)) ? pos_t'(x_min) : pos_t'(xe - 12'(step));
    end else if (right && !left) begin
      return ((xe + 12'(step)) > 12'(x_max)) ? pos_t'(x_max) : pos_t'(xe + 12'(step));
    end
    return x;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Rising-edge detector on vertical blank; one-cycle tick per frame.
module frame_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic tick_o
);

  logic level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) level_q <= 1'b0;
    else       level_q <= level_i;
  end

  assign tick_o = level_i & ~level_q;

endmodule

// File: rtl/jerry_ctl.sv
// Jerry movement controller: per-frame horizontal stepping and jump/gravity FSM.
// state    | meaning
// STANDING | on the floor, jump request starts a rise
// JUMP_UP  | rising, velocity decays by gravity each frame
// FALL     | descending, velocity grows up to V_MAX until the floor
module jerry_ctl import game_pkg::*; #(
  parameter int unsigned X_START  = JERRY_X_START,
  parameter int unsigned X_MIN    = JERRY_X_MIN,
  parameter int unsigned X_MAX    = JERRY_X_MAX,
  parameter int unsigned GROUND_Y = JERRY_GROUND_Y,
  parameter int unsigned Y_MIN    = JERRY_Y_MIN,
  parameter int unsigned STEP_X   = JERRY_STEP_X,
  parameter int unsigned JUMP_V0  = JERRY_JUMP_V0,
  parameter int unsigned GRAVITY  = JERRY_GRAVITY,
  parameter int unsigned V_MAX    = JERRY_V_MAX
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vblnk_i,
  input  logic        left_i,
  input  logic        right_i,
  input  logic        jump_i,
  input  logic        freeze_i,
  output logic [10:0] jerry_x_o,
  output logic [10:0] jerry_y_o,
  output logic        airborne_o
);

  logic         tick;
  logic         upd;
  jerry_state_t state_q, state_d;
  pos_t         x_q, x_d;
  pos_t         y_q, y_d;
  vel_t         vel_q, vel_d;

  logic [POS_W:0]   y_ext;
  logic [POS_W:0]   vel_ext;
  logic [POS_W:0]   y_fall;
  logic [VEL_W:0]   vel_inc;
  vel_t             vel_fall;

  frame_tick u_frame_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .level_i(vblnk_i),
    .tick_o (tick)
  );

  // Pause freezes everything except the vblank edge tracker inside frame_tick.
  assign upd = tick & ~freeze_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= STANDING;
      x_q     <= pos_t'(X_START);
      y_q     <= pos_t'(GROUND_Y);
      vel_q   <= '0;
    end else if (upd) begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
    end
  end

  always_comb begin
    x_d = step_x(x_q, left_i, right_i, STEP_X, X_MIN, X_MAX);
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    vel_d    = vel_q;
    y_ext    = {1'b0, y_q};
    vel_ext  = {{(POS_W + 1 - VEL_W){1'b0}}, vel_q};
    vel_inc  = {1'b0, vel_q} + 7'(GRAVITY);
    vel_fall = (vel_inc > 7'(V_MAX)) ? vel_t'(V_MAX) : vel_inc[VEL_W-1:0];
    y_fall   = y_ext + {{(POS_W + 1 - VEL_W){1'b0}}, vel_fall};
    unique case (state_q)
      STANDING: begin
        if (jump_i) begin
          state_d = JUMP_UP;
          vel_d   = vel_t'(JUMP_V0);
        end
      end
      JUMP_UP: begin
        // Compare as y < Y_MIN + vel so the subtraction never underflows.
        if (y_ext < (12'(Y_MIN) + vel_ext)) begin
          y_d     = pos_t'(Y_MIN);
          vel_d   = '0;
          state_d = FALL;
        end else begin
          y_d = y_q - {{(POS_W - VEL_W){1'b0}}, vel_q};
          if (vel_q <= vel_t'(GRAVITY)) begin
            vel_d   = '0;
            state_d = FALL;
          end else begin
            vel_d = vel_q - vel_t'(GRAVITY);
          end
        end
      end
      FALL: begin
        if (y_fall >= 12'(GROUND_Y)) begin
          y_d     = pos_t'(GROUND_Y);
          vel_d   = '0;
          state_d = STANDING;
        end else begin
          y_d   = y_fall[POS_W-1:0];
          vel_d = vel_fall;
        end
      end
      default: begin
        y_d     = pos_t'(GROUND_Y);
        vel_d   = '0;
        state_d = STANDING;
      end
    endcase
  end

  always_comb begin
    jerry_x_o  = x_q;
    jerry_y_o  = y_q;
    airborne_o = (state_q != STANDING);
  end

endmodule
